// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction encodings, ALU ops and the ID/EX pipeline payload.
// Also carries the ID/EX control FSM states and the bubble ALU op.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int IMM_W  = 16;
  localparam int SHAM_W = 5;
  localparam int ALU_W  = 4;
  localparam int OP_W   = 6;
  localparam int FUNC_W = 6;
  localparam int CNT_W  = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;
  typedef logic [IMM_W-1:0]  imm16_t;
  typedef logic [SHAM_W-1:0] shamt_t;

  typedef enum logic [ALU_W-1:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [OP_W-1:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    JAL   = 6'h03,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    ADDI  = 6'h08,
    ADDIU = 6'h09,
    SLTI  = 6'h0A,
    SLTIU = 6'h0B,
    ANDI  = 6'h0C,
    ORI   = 6'h0D,
    XORI  = 6'h0E,
    LUI   = 6'h0F,
    LW    = 6'h23,
    SW    = 6'h2B,
    HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [FUNC_W-1:0] {
    SLL  = 6'h00,
    SRL  = 6'h02,
    JR   = 6'h08,
    ADD  = 6'h20,
    ADDU = 6'h21,
    SUB  = 6'h22,
    SUBU = 6'h23,
    AND  = 6'h24,
    OR   = 6'h25,
    XOR  = 6'h26,
    NOR  = 6'h27,
    SLT  = 6'h2A,
    SLTU = 6'h2B
  } funct_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FLUSH_PEND = 2'd1,
    HALTED     = 2'd2
  } idex_state_t;

  localparam aluop_t BUBBLE_ALUOP = ALU_SLL;

  // Everything that crosses the ID/EX boundary, packed so it can be held in one register.
  typedef struct packed {
    word_t    instr;
    word_t    pcplus4;
    word_t    rdat1;
    word_t    rdat2;
    regbits_t rs;
    regbits_t rt;
    regbits_t rd;
    imm16_t   imm16;
    shamt_t   shamt;
    aluop_t   AluOp;
    opcode_t  InstrOp;
    funct_t   InstrFunc;
    logic     MemToReg;
    logic     AluSrc;
    logic     JType;
    logic     RegDst;
    logic     regWEN;
    logic     PcSrc;
    logic     JReg;
    logic     Halt;
    logic     dMemWEN;
    logic     dMemREN;
  } idex_pkt_t;

endpackage

// File: rtl/idex_if.sv
// Decode-to-execute interface: *_in fields come from decode, *_out fields feed execute.
interface idex_if;
  import cpu_types_pkg::*;

  word_t    instr_in,     instr_out;
  word_t    pcplus4_in,   pcplus4_out;
  word_t    rdat1_in,     rdat1_out;
  word_t    rdat2_in,     rdat2_out;
  regbits_t rs_in,        rs_out;
  regbits_t rt_in,        rt_out;
  regbits_t rd_in,        rd_out;
  imm16_t   imm16_in,     imm16_out;
  shamt_t   shamt_in,     shamt_out;
  aluop_t   AluOp_in,     AluOp_out;
  opcode_t  InstrOp_in,   InstrOp_out;
  funct_t   InstrFunc_in, InstrFunc_out;
  logic     MemToReg_in,  MemToReg_out;
  logic     AluSrc_in,    AluSrc_out;
  logic     JType_in,     JType_out;
  logic     RegDst_in,    RegDst_out;
  logic     regWEN_in,    regWEN_out;
  logic     PcSrc_in,     PcSrc_out;
  logic     JReg_in,      JReg_out;
  logic     Halt_in,      Halt_out;
  logic     dMemWEN_in,   dMemWEN_out;
  logic     dMemREN_in,   dMemREN_out;

  modport idex (
    input  instr_in, pcplus4_in, rdat1_in, rdat2_in, rs_in, rt_in, rd_in,
           imm16_in, shamt_in, AluOp_in, InstrOp_in, InstrFunc_in,
           MemToReg_in, AluSrc_in, JType_in, RegDst_in, regWEN_in, PcSrc_in,
           JReg_in, Halt_in, dMemWEN_in, dMemREN_in,
    output instr_out, pcplus4_out, rdat1_out, rdat2_out, rs_out, rt_out, rd_out,
           imm16_out, shamt_out, AluOp_out, InstrOp_out, InstrFunc_out,
           MemToReg_out, AluSrc_out, JType_out, RegDst_out, regWEN_out, PcSrc_out,
           JReg_out, Halt_out, dMemWEN_out, dMemREN_out
  );

endinterface

// File: rtl/idex_reg.sv
// ID/EX pipeline register with load-use bubbles, deferred flush and a sticky halt lock.
// All outputs come straight from flops; no input reaches an output combinationally.
module idex_reg
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  idex_if.idex              idexif,
  input  logic              en,
  input  logic              hazard,
  input  logic              flush,
  output logic              valid_out,
  output logic              halted,
  output logic [CNT_W-1:0]  bubble_cnt
);

  idex_state_t       state_q, state_d;
  idex_pkt_t         pkt_q, pkt_d;
  idex_pkt_t         in_pkt;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_bubble;

  function automatic idex_pkt_t bubble_pkt();
    idex_pkt_t b;
    b           = '0;
    b.AluOp     = BUBBLE_ALUOP;
    b.InstrOp   = RTYPE;
    b.InstrFunc = SLL;
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_comb begin
    in_pkt           = '0;
    in_pkt.instr     = idexif.instr_in;
    in_pkt.pcplus4   = idexif.pcplus4_in;
    in_pkt.rdat1     = idexif.rdat1_in;
    in_pkt.rdat2     = idexif.rdat2_in;
    in_pkt.rs        = idexif.rs_in;
    in_pkt.rt        = idexif.rt_in;
    in_pkt.rd        = idexif.rd_in;
    in_pkt.imm16     = idexif.imm16_in;
    in_pkt.shamt     = idexif.shamt_in;
    in_pkt.AluOp     = idexif.AluOp_in;
    in_pkt.InstrOp   = idexif.InstrOp_in;
    in_pkt.InstrFunc = idexif.InstrFunc_in;
    in_pkt.MemToReg  = idexif.MemToReg_in;
    in_pkt.AluSrc    = idexif.AluSrc_in;
    in_pkt.JType     = idexif.JType_in;
    in_pkt.RegDst    = idexif.RegDst_in;
    in_pkt.regWEN    = idexif.regWEN_in;
    in_pkt.PcSrc     = idexif.PcSrc_in;
    in_pkt.JReg      = idexif.JReg_in;
    in_pkt.Halt      = idexif.Halt_in;
    in_pkt.dMemWEN   = idexif.dMemWEN_in;
    in_pkt.dMemREN   = idexif.dMemREN_in;
  end

  // Next state / next register contents; holding is the default in every state.
  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    load_bubble = 1'b0;
    unique case (state_q)
      RUN: begin
        if (flush) begin
          if (en) load_bubble = 1'b1;
          else    state_d     = FLUSH_PEND;
        end else if (hazard && en) begin
          load_bubble = 1'b1;
        end else if (en) begin
          pkt_d   = in_pkt;
          valid_d = 1'b1;
          if (idexif.Halt_in) state_d = HALTED;
        end
      end
      FLUSH_PEND: begin
        // The squash was owed to the instruction sitting in decode when flush rose.
        if (en) begin
          load_bubble = 1'b1;
          state_d     = RUN;
        end
      end
      HALTED: begin
      end
      default: state_d = RUN;
    endcase
    if (load_bubble) begin
      pkt_d   = bubble_pkt();
      valid_d = 1'b0;
      cnt_d   = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      pkt_q   <= bubble_pkt();
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_out  = valid_q;
  assign halted     = (state_q == HALTED);
  assign bubble_cnt = cnt_q;

  assign idexif.instr_out     = pkt_q.instr;
  assign idexif.pcplus4_out   = pkt_q.pcplus4;
  assign idexif.rdat1_out     = pkt_q.rdat1;
  assign idexif.rdat2_out     = pkt_q.rdat2;
  assign idexif.rs_out        = pkt_q.rs;
  assign idexif.rt_out        = pkt_q.rt;
  assign idexif.rd_out        = pkt_q.rd;
  assign idexif.imm16_out     = pkt_q.imm16;
  assign idexif.shamt_out     = pkt_q.shamt;
  assign idexif.AluOp_out     = pkt_q.AluOp;
  assign idexif.InstrOp_out   = pkt_q.InstrOp;
  assign idexif.InstrFunc_out = pkt_q.InstrFunc;
  assign idexif.MemToReg_out  = pkt_q.MemToReg;
  assign idexif.AluSrc_out    = pkt_q.AluSrc;
  assign idexif.JType_out     = pkt_q.JType;
  assign idexif.RegDst_out    = pkt_q.RegDst;
  assign idexif.regWEN_out    = pkt_q.regWEN;
  assign idexif.PcSrc_out     = pkt_q.PcSrc;
  assign idexif.JReg_out      = pkt_q.JReg;
  assign idexif.Halt_out      = pkt_q.Halt;
  assign idexif.dMemWEN_out   = pkt_q.dMemWEN;
  assign idexif.dMemREN_out   = pkt_q.dMemREN;

endmodule

// File: tb/tb_idex_reg.sv
// Directed bench for idex_reg: reset, latch, load-use, deferred flush, halt lock.
module tb_idex_reg;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        en, hazard, flush;
  logic        valid_out, halted;
  logic [15:0] bubble_cnt;
  int          passed = 0;
  int          total  = 0;

  idex_if idexif ();

  idex_reg dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .idexif     (idexif),
    .en         (en),
    .hazard     (hazard),
    .flush      (flush),
    .valid_out  (valid_out),
    .halted     (halted),
    .bubble_cnt (bubble_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic zero_inputs();
    idexif.instr_in = '0;  idexif.pcplus4_in = '0; idexif.rdat1_in = '0;
    idexif.rdat2_in = '0;  idexif.rs_in = '0;      idexif.rt_in = '0;
    idexif.rd_in = '0;     idexif.imm16_in = '0;   idexif.shamt_in = '0;
    idexif.AluOp_in = ALU_SLL; idexif.InstrOp_in = RTYPE; idexif.InstrFunc_in = SLL;
    idexif.MemToReg_in = 0; idexif.AluSrc_in = 0; idexif.JType_in = 0;
    idexif.RegDst_in = 0;   idexif.regWEN_in = 0; idexif.PcSrc_in = 0;
    idexif.JReg_in = 0;     idexif.Halt_in = 0;   idexif.dMemWEN_in = 0;
    idexif.dMemREN_in = 0;
  endtask

  task automatic nonzero_inputs();
    idexif.instr_in = 32'hDEADBEEF; idexif.pcplus4_in = 32'h44; idexif.rdat1_in = 32'h11;
    idexif.rdat2_in = 32'h22; idexif.rs_in = 5'd3; idexif.rt_in = 5'd4;
    idexif.rd_in = 5'd5; idexif.imm16_in = 16'h1234; idexif.shamt_in = 5'd7;
    idexif.AluOp_in = ALU_ADD; idexif.InstrOp_in = LW; idexif.InstrFunc_in = ADD;
    idexif.MemToReg_in = 1; idexif.AluSrc_in = 1; idexif.JType_in = 1;
    idexif.RegDst_in = 1;   idexif.regWEN_in = 1; idexif.PcSrc_in = 1;
    idexif.JReg_in = 1;     idexif.Halt_in = 1;   idexif.dMemWEN_in = 1;
    idexif.dMemREN_in = 1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_regWEN"}, idexif.regWEN_out, 1'b0);
    check({tag, "_AluOp"},  idexif.AluOp_out,  ALU_SLL);
    check({tag, "_valid"},  valid_out,         1'b0);
    check({tag, "_cnt"},    bubble_cnt,        16'd0);
    check({tag, "_halted"}, halted,            1'b0);
    check({tag, "_instr"},  idexif.instr_out,  32'h0);
  endtask

  initial begin
    en = 0; hazard = 0; flush = 0;
    nonzero_inputs();
    nRST = 0;
    #2;
    check_reset_vals("rst_async");
    @(negedge CLK);
    nRST = 1;
    tick();
    check_reset_vals("rst_edge");

    // Normal latch of a lw
    zero_inputs();
    idexif.instr_in = 32'h8C220004; idexif.InstrOp_in = LW;
    idexif.dMemREN_in = 1; idexif.rt_in = 5'd2; en = 1;
    tick();
    check("lat_instr", idexif.instr_out,   32'h8C220004);
    check("lat_dren",  idexif.dMemREN_out, 1'b1);
    check("lat_rt",    idexif.rt_out,      5'd2);
    check("lat_valid", valid_out,          1'b1);
    check("lat_op",    idexif.InstrOp_out, LW);
    en = 0; idexif.instr_in = 32'h01234567; idexif.dMemREN_in = 0; idexif.rt_in = 5'd9;
    tick();
    check("hold_instr", idexif.instr_out,   32'h8C220004);
    check("hold_dren",  idexif.dMemREN_out, 1'b1);
    check("hold_rt",    idexif.rt_out,      5'd2);
    check("hold_valid", valid_out,          1'b1);

    // Load-use bubbles
    hazard = 1; en = 1; idexif.regWEN_in = 1;
    tick();
    check("lu_regwen", idexif.regWEN_out,  1'b0);
    check("lu_instr",  idexif.instr_out,   32'h0);
    check("lu_valid",  valid_out,          1'b0);
    check("lu_cnt1",   bubble_cnt,         16'd1);
    check("lu_func",   idexif.InstrFunc_out, SLL);
    check("lu_op",     idexif.InstrOp_out, RTYPE);
    tick();
    check("lu_cnt2",   bubble_cnt,         16'd2);

    // Hazard with en low holds
    en = 0; zero_inputs(); idexif.instr_in = 32'h20010005; idexif.regWEN_in = 1;
    tick();
    check("hz_noen_cnt", bubble_cnt, 16'd2);
    hazard = 0; en = 1;
    tick();
    check("addi_instr", idexif.instr_out, 32'h20010005);
    check("addi_valid", valid_out,        1'b1);

    // Deferred flush
    en = 0; flush = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("df_hold_instr", idexif.instr_out, 32'h20010005);
      check("df_hold_valid", valid_out,        1'b1);
    end
    check("df_hold_cnt", bubble_cnt, 16'd2);
    flush = 0; en = 1; zero_inputs();
    idexif.instr_in = 32'hAC220008; idexif.dMemWEN_in = 1; idexif.InstrOp_in = SW;
    tick();
    check("df_bub_dwen",  idexif.dMemWEN_out, 1'b0);
    check("df_bub_instr", idexif.instr_out,   32'h0);
    check("df_bub_valid", valid_out,          1'b0);
    check("df_bub_cnt",   bubble_cnt,         16'd3);
    tick();
    check("df_lat_instr", idexif.instr_out,   32'hAC220008);
    check("df_lat_dwen",  idexif.dMemWEN_out, 1'b1);
    check("df_lat_valid", valid_out,          1'b1);

    // Flush held across en edges: one bubble per edge
    flush = 1;
    tick();
    tick();
    check("fh_cnt", bubble_cnt, 16'd5);
    flush = 0; idexif.instr_in = 32'h00221820;
    tick();
    check("fh_after_instr", idexif.instr_out, 32'h00221820);
    check("fh_after_cnt",   bubble_cnt,       16'd5);

    // Squashed halts
    zero_inputs(); idexif.Halt_in = 1; idexif.instr_in = 32'hFFFFFFFF; flush = 1;
    tick();
    check("sqf_haltout", idexif.Halt_out, 1'b0);
    check("sqf_halted",  halted,          1'b0);
    check("sqf_cnt",     bubble_cnt,      16'd6);
    flush = 0; hazard = 1;
    tick();
    check("sqh_halted",  halted,          1'b0);
    check("sqh_cnt",     bubble_cnt,      16'd7);

    // Halt lock
    hazard = 0;
    tick();
    check("h_haltout", idexif.Halt_out,  1'b1);
    check("h_halted",  halted,           1'b1);
    check("h_instr",   idexif.instr_out, 32'hFFFFFFFF);
    zero_inputs(); idexif.instr_in = 32'h12345678; idexif.regWEN_in = 1;
    en = 1; flush = 1; tick();
    flush = 0; hazard = 1; tick();
    hazard = 0; en = 0; flush = 1; tick();
    flush = 0; en = 1; tick();
    check("hf_instr",  idexif.instr_out,  32'hFFFFFFFF);
    check("hf_regwen", idexif.regWEN_out, 1'b0);
    check("hf_halted", halted,            1'b1);
    check("hf_valid",  valid_out,         1'b1);
    check("hf_cnt",    bubble_cnt,        16'd7);
    #2 nRST = 0;
    #1;
    check_reset_vals("hrst");
    @(negedge CLK);
    nRST = 1;

    // Reset in FLUSH_PEND discards the pending squash
    en = 1; zero_inputs(); idexif.instr_in = 32'h34420001;
    tick();
    check("fp_lat", idexif.instr_out, 32'h34420001);
    en = 0; flush = 1;
    tick();
    flush = 0;
    #2 nRST = 0;
    #1;
    check("fp_rst_instr", idexif.instr_out, 32'h0);
    @(negedge CLK);
    nRST = 1; en = 1; idexif.instr_in = 32'h3C031000;
    tick();
    check("fp_post_instr", idexif.instr_out, 32'h3C031000);
    check("fp_post_valid", valid_out,        1'b1);
    check("fp_post_cnt",   bubble_cnt,       16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
